// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, parity mode constants and baud helpers
// for the UART transmitter and the future receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_READ   = ST_READ,
        S_LOAD   = ST_LOAD,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    function automatic int unsigned calc_clocks_per_bit(input int unsigned clk_hz,
                                                         input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 32-bit bit-time counter counting 0..CLOCKS_PER_BIT-1 with a
// synchronous clear; tick marks the terminal count.
module uart_baud_gen #(
    parameter int unsigned CLOCKS_PER_BIT = 32'd868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] TERMINAL = 32'(CLOCKS_PER_BIT - 32'd1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 32'd0;
        end else if (cnt_q == TERMINAL) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERMINAL) && !clr;

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter fed by a read-latency-1 FIFO.
// Runtime parity is built only when UART_TX_FRAME_PARITY_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd115200,
    parameter int unsigned WORD_WIDTH      = 32'd8,
    parameter int unsigned STOP_BITS       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
    input  logic [1:0]            parity_mode,
    output logic                  re,
    output logic                  dout,
    output logic                  busy
);

    localparam int unsigned CLOCKS_PER_BIT = calc_clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned BIT_CNT_W      = $clog2(WORD_WIDTH + 32'd1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(WORD_WIDTH - 32'd1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ONE   = BIT_CNT_W'(32'd1);
    localparam logic                 LAST_STOP_BIT = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;

    if (CLOCKS_PER_BIT < 32'd2) begin : g_bad_cpb
        $error("uart_tx_frame: CLOCKS_PER_BIT must be at least 2");
    end
    if ((WORD_WIDTH < 32'd5) || (WORD_WIDTH > 32'd9)) begin : g_bad_width
        $error("uart_tx_frame: WORD_WIDTH must be in 5..9");
    end
    if ((STOP_BITS != 32'd1) && (STOP_BITS != 32'd2)) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    tx_state_e             state_q;
    logic                  re_q;
    logic                  dout_q;
    logic                  busy_q;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  stop_cnt_q;
    logic                  baud_clr_s;
    logic                  baud_tick_s;

`ifdef UART_TX_FRAME_PARITY_EN
    logic par_bit_q;
    logic par_en_q;

    function automatic logic calc_parity(input logic [WORD_WIDTH-1:0] word,
                                         input logic [1:0]            mode);
        return (mode == PARITY_ODD) ? ~(^word) : (^word);
    endfunction
`else
    logic unused_parity_mode_s;
    assign unused_parity_mode_s = ^parity_mode;
`endif

    // The bit timer restarts from zero so the start bit is a full bit time.
    assign baud_clr_s = (state_q == S_IDLE) || (state_q == S_READ) || (state_q == S_LOAD);

    uart_baud_gen #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr_s),
        .tick (baud_tick_s)
    );

    // Frame sequencer with registered line, strobe and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            re_q       <= 1'b0;
            dout_q     <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
`endif
        end else begin
            re_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    dout_q <= 1'b1;
                    if (!empty) begin
                        state_q <= S_READ;
                        re_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q    <= din;
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
                    par_bit_q  <= calc_parity(din, parity_mode);
                    par_en_q   <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
`endif
                    dout_q     <= 1'b0;
                    state_q    <= S_START;
                end
                S_START: begin
                    if (baud_tick_s) begin
                        dout_q  <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                // dout already carries shift_q[0]; on each tick present the next bit.
                S_DATA: begin
                    if (baud_tick_s) begin
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_ONE;
                        shift_q   <= {1'b1, shift_q[WORD_WIDTH-1:1]};
                        if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef UART_TX_FRAME_PARITY_EN
                            if (par_en_q) begin
                                dout_q  <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                dout_q  <= 1'b1;
                                state_q <= S_STOP;
                            end
`else
                            dout_q  <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            dout_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_FRAME_PARITY_EN
                S_PARITY: begin
                    if (baud_tick_s) begin
                        dout_q  <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick_s) begin
                        if (stop_cnt_q == LAST_STOP_BIT) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    dout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign re   = re_q;
    assign dout = dout_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven frame checks on three transmitter builds
// (8N1, 8 bits/2 stop, 5 bits/1 stop) plus back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int CPB = 10;
`ifdef UART_TX_FRAME_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] empty_v;
    logic [7:0] din_v;
    logic [1:0] mode;
    logic [2:0] re_v;
    logic [2:0] dout_v;
    logic [2:0] busy_v;

    int n_tests = 0;
    int n_fail  = 0;

    logic tr_dout [256];
    logic tr_re   [256];
    logic tr_busy [256];

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic [1:0] mode;
        logic [1:0] mode_late;
        logic       pbit;
        int         busy_fall;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
                    .WORD_WIDTH(32'd8), .STOP_BITS(32'd1)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_v), .empty(empty_v[0]), .parity_mode(mode),
        .re(re_v[0]), .dout(dout_v[0]), .busy(busy_v[0]));

    uart_tx_frame #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
                    .WORD_WIDTH(32'd8), .STOP_BITS(32'd2)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_v), .empty(empty_v[1]), .parity_mode(mode),
        .re(re_v[1]), .dout(dout_v[1]), .busy(busy_v[1]));

    uart_tx_frame #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
                    .WORD_WIDTH(32'd5), .STOP_BITS(32'd1)) u_dut_c (
        .clk(clk), .rst(rst), .din(din_v[4:0]), .empty(empty_v[2]), .parity_mode(mode),
        .re(re_v[2]), .dout(dout_v[2]), .busy(busy_v[2]));

    function automatic logic exp_line(input int c, input int start, input int ww,
                                      input logic pen, input logic pbit, input logic [7:0] w);
        int rel;
        int b;
        rel = c - start;
        if (rel < 0) return 1'b1;
        b = rel / CPB;
        if (b == 0) return 1'b0;
        if (b <= ww) return w[b-1];
        if (pen && (b == ww + 1)) return pbit;
        return 1'b1;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    // Drop empty at cycle 0 and record the chosen DUT's outputs for ncyc cycles.
    task automatic run_trace(input int sel, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [1:0] m_late, input int low_until, input int ncyc);
        @(posedge clk);
        #1;
        din_v        = w1;
        empty_v[sel] = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            tr_dout[c] = dout_v[sel];
            tr_re[c]   = re_v[sel];
            tr_busy[c] = busy_v[sel];
            @(posedge clk);
            #1;
            if (c >= low_until) empty_v[sel] = 1'b1;
            if (c == 2) begin
                din_v = w2;
                mode  = m_late;
            end
        end
    endtask

    task automatic check_trace(input string name, input int ww, input logic pen, input logic pbit,
                               input logic [7:0] w1, input logic [7:0] w2, input int fall,
                               input logic two, input int ncyc);
        int   bad [3];
        int   first [3];
        logic fact [3];
        logic fexp [3];
        logic act [3];
        logic exp [3];
        string sig [3];
        sig[0] = "dout";
        sig[1] = "re";
        sig[2] = "busy";
        for (int k = 0; k < 3; k++) begin
            bad[k]   = 0;
            first[k] = -1;
            fact[k]  = 1'b0;
            fexp[k]  = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            if (two && (c >= fall + 3)) exp[0] = exp_line(c, fall + 3, ww, 1'b0, 1'b0, w2);
            else                        exp[0] = exp_line(c, 3, ww, pen, pbit, w1);
            exp[1] = (c == 1) || (two && (c == fall + 1));
            exp[2] = ((c >= 1) && (c < fall)) || (two && (c >= fall + 1) && (c < 2 * fall));
            act[0] = tr_dout[c];
            act[1] = tr_re[c];
            act[2] = tr_busy[c];
            for (int k = 0; k < 3; k++) begin
                if (act[k] !== exp[k]) begin
                    if (bad[k] == 0) begin
                        first[k] = c;
                        fact[k]  = act[k];
                        fexp[k]  = exp[k];
                    end
                    bad[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bad[k] != 0) begin
                n_fail++;
                $display("FAIL %s_%s: %0d bad cycles, first at cycle %0d got %0b want %0b",
                         name, sig[k], bad[k], first[k], fact[k], fexp[k]);
            end
        end
    endtask

    initial begin
        int   ww;
        int   bad;
        logic pen;

        vecs[0] = '{0, 8'h55, 2'b00, 2'b00, 1'b0, 103};
        vecs[1] = '{0, 8'h07, 2'b01, 2'b00, 1'b1, 103 + 10 * PEN};
        vecs[2] = '{0, 8'h07, 2'b10, 2'b10, 1'b0, 103 + 10 * PEN};
        vecs[3] = '{1, 8'h00, 2'b00, 2'b00, 1'b0, 113};
        vecs[4] = '{2, 8'h1F, 2'b01, 2'b01, 1'b1, 73 + 10 * PEN};
        vecs[5] = '{0, 8'hA5, 2'b11, 2'b11, 1'b0, 103};
        vecs[6] = '{2, 8'h0A, 2'b10, 2'b00, 1'b1, 73 + 10 * PEN};

        rst     = 1'b1;
        empty_v = 3'b111;
        din_v   = 8'h00;
        mode    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check1($sformatf("reset_dout_%0d", k), dout_v[k], 1'b1);
            check1($sformatf("reset_re_%0d", k),   re_v[k],   1'b0);
            check1($sformatf("reset_busy_%0d", k), busy_v[k], 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            ww   = (vecs[i].sel == 2) ? 5 : 8;
            pen  = (PEN == 1) && ((vecs[i].mode == 2'b01) || (vecs[i].mode == 2'b10));
            mode = vecs[i].mode;
            run_trace(vecs[i].sel, vecs[i].word, vecs[i].word, vecs[i].mode_late, 0,
                      vecs[i].busy_fall + 10);
            check_trace($sformatf("vec%0d", i), ww, pen, vecs[i].pbit, vecs[i].word,
                        vecs[i].word, vecs[i].busy_fall, 1'b0, vecs[i].busy_fall + 10);
            repeat (3) @(posedge clk);
        end

        // Two queued words with empty held low through the first frame.
        mode = 2'b00;
        run_trace(0, 8'hA5, 8'h3C, 2'b00, 103, 220);
        check_trace("b2b", 8, 1'b0, 1'b0, 8'hA5, 8'h3C, 103, 1'b1, 220);
        repeat (3) @(posedge clk);

        // Reset asserted at cycle 50, mid data bit 3 of 8'h55.
        mode = 2'b00;
        @(posedge clk);
        #1;
        din_v      = 8'h55;
        empty_v[0] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 49) begin
                check1("pre_rst_dout", dout_v[0], exp_line(49, 3, 8, 1'b0, 1'b0, 8'h55));
                check1("pre_rst_busy", busy_v[0], 1'b1);
            end
            @(posedge clk);
            #1;
            empty_v[0] = 1'b1;
        end
        rst = 1'b1;
        #1;
        check1("rst_dout", dout_v[0], 1'b1);
        check1("rst_busy", busy_v[0], 1'b0);
        check1("rst_re",   re_v[0],   1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if ((re_v[0] !== 1'b0) || (dout_v[0] !== 1'b1) || (busy_v[0] !== 1'b0)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_rst_idle: %0d cycles not idle, want 0", bad);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
